// File: rtl/cdb_slot_scheduler_if.sv
// cdb_slot_scheduler_if: handshake bundle between the issue queues and the
// CDB slot scheduler. The queue side is the master and the scheduler is the slave.
// Optional statistics ports exist only when CDB_STATS_EN is defined.
interface cdb_slot_scheduler_if;
  logic       alu_ready;
  logic       mul_ready;
  logic       div_ready;
  logic       div_busy;
  logic       ls_ready;
  logic       alu_done;
  logic       mul_done;
  logic       div_done;
  logic       ls_done;
  logic       cdb_valid;
  logic [1:0] cdb_sel;
`ifdef CDB_STATS_EN
  logic [31:0] cdb_busy_cnt;
  logic [31:0] stall_cnt;
`endif

  modport master (
    output alu_ready, mul_ready, div_ready, div_busy, ls_ready,
`ifdef CDB_STATS_EN
    input  cdb_busy_cnt, stall_cnt,
`endif
    input  alu_done, mul_done, div_done, ls_done, cdb_valid, cdb_sel
  );

  modport slave (
    input  alu_ready, mul_ready, div_ready, div_busy, ls_ready,
`ifdef CDB_STATS_EN
    output cdb_busy_cnt, stall_cnt,
`endif
    output alu_done, mul_done, div_done, ls_done, cdb_valid, cdb_sel
  );
endinterface

// File: rtl/cdb_slot_scheduler.sv
// cdb_slot_scheduler: books future common-data-bus slots so that ALU, MUL,
// DIV and LS results never collide. MUL/DIV reserve their slot at grant time;
// ALU/LS take slot 0 when it is free, alternating when both request.
// Optional feature: define CDB_STATS_EN to add CDB busy and ALU/LS stall counters.
module cdb_slot_scheduler #(
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 8,
  parameter int SLOT_DEPTH = 16,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic rst,
  cdb_slot_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2,
    SRC_LS  = 2'd3
  } src_e;

  localparam int StarveW = $clog2(STARVE_MAX + 2);

  logic [SLOT_DEPTH-1:0] slotValid_q, slotValid_d;
  src_e                  slotSrc_q [SLOT_DEPTH];
  src_e                  slotSrc_d [SLOT_DEPTH];
  logic                  rrPtr_q, rrPtr_d;
  logic [StarveW-1:0]    starveCnt_q, starveCnt_d;

  logic hold;
  logic aluGrant, lsGrant, mulGrant, divGrant;
  logic cdbValid;
  src_e cdbSel;

  assign hold = (starveCnt_q >= StarveW'(STARVE_MAX));

  // Fixed-latency grants: each needs its landing slot free and no starvation hold.
  always_comb begin
    mulGrant = 1'b0;
    divGrant = 1'b0;
    if (!rst && !hold) begin
      mulGrant = bus.mul_ready & ~slotValid_q[MUL_LAT];
      divGrant = bus.div_ready & ~bus.div_busy & ~slotValid_q[DIV_LAT];
    end
  end

  // ALU/LS arbitration for slot 0; on a tie the pointer moves to the loser.
  always_comb begin
    aluGrant = 1'b0;
    lsGrant  = 1'b0;
    rrPtr_d  = rrPtr_q;
    if (!rst && !slotValid_q[0]) begin
      if (bus.alu_ready && bus.ls_ready) begin
        if (!rrPtr_q) begin
          aluGrant = 1'b1;
          rrPtr_d  = 1'b1;
        end else begin
          lsGrant  = 1'b1;
          rrPtr_d  = 1'b0;
        end
      end else if (bus.alu_ready) begin
        aluGrant = 1'b1;
      end else if (bus.ls_ready) begin
        lsGrant = 1'b1;
      end
    end
  end

  // CDB source: a booked slot 0 wins, otherwise the zero-latency winner.
  always_comb begin
    cdbValid = 1'b0;
    cdbSel   = SRC_ALU;
    if (!rst) begin
      if (slotValid_q[0]) begin
        cdbValid = 1'b1;
        cdbSel   = slotSrc_q[0];
      end else if (aluGrant) begin
        cdbValid = 1'b1;
        cdbSel   = SRC_ALU;
      end else if (lsGrant) begin
        cdbValid = 1'b1;
        cdbSel   = SRC_LS;
      end
    end
  end

  // Slot table advances one cycle; new bookings land at LAT-1 after the shift.
  always_comb begin
    for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
      slotValid_d[k] = slotValid_q[k+1];
      slotSrc_d[k]   = slotSrc_q[k+1];
    end
    slotValid_d[SLOT_DEPTH-1] = 1'b0;
    slotSrc_d[SLOT_DEPTH-1]   = SRC_ALU;
    if (mulGrant) begin
      slotValid_d[MUL_LAT-1] = 1'b1;
      slotSrc_d[MUL_LAT-1]   = SRC_MUL;
    end
    if (divGrant) begin
      slotValid_d[DIV_LAT-1] = 1'b1;
      slotSrc_d[DIV_LAT-1]   = SRC_DIV;
    end
  end

  // Starvation counter: counts ALU/LS cycles lost to booked slots, saturating.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (aluGrant || lsGrant || !(bus.alu_ready || bus.ls_ready)) begin
      starveCnt_d = '0;
    end else if (slotValid_q[0] && (starveCnt_q != '1)) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  // State registers; reset drops every booked slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid_q <= '0;
      for (int k = 0; k < SLOT_DEPTH; k++) slotSrc_q[k] <= SRC_ALU;
      rrPtr_q     <= 1'b0;
      starveCnt_q <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      for (int k = 0; k < SLOT_DEPTH; k++) slotSrc_q[k] <= slotSrc_d[k];
      rrPtr_q     <= rrPtr_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  assign bus.alu_done  = aluGrant;
  assign bus.ls_done   = lsGrant;
  assign bus.mul_done  = mulGrant;
  assign bus.div_done  = divGrant;
  assign bus.cdb_valid = cdbValid;
  assign bus.cdb_sel   = cdbSel;

`ifdef CDB_STATS_EN
  logic [31:0] busyCnt_q, stallCnt_q;

  // Saturating statistics: CDB occupancy and ALU/LS cycles left ungranted.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyCnt_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      if (cdbValid && (busyCnt_q != '1)) busyCnt_q <= busyCnt_q + 1'b1;
      if ((bus.alu_ready || bus.ls_ready) && !aluGrant && !lsGrant && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  assign bus.cdb_busy_cnt = busyCnt_q;
  assign bus.stall_cnt    = stallCnt_q;
`endif

endmodule
